mem_copy_engine: RTL and testbench

Initiator-side block-transfer engine that drives the single-port data memory interface (Adr/MWD/MWR/MOE/MRD). It copies a block of words from a source to a destination word address, or fills a block with a constant pattern, on a start/busy/done handshake. It sits between the controller (or a host-command decoder) and the data memory. It takes the memory port for the whole duration of a transfer.

---
 rtl/mem_copy_if.sv | 32 +++
 rtl/mem_copy_engine.sv | 99 +++++++++
 tb/tb_mem_copy_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_if.sv
// Command and memory-port bundle for mem_copy_engine: start/busy/done control
// plus the single-port data memory signals (Adr/MWD/MWR/MOE/MRD).
interface mem_copy_if #(
    parameter int LEN_W = 7
);
    logic             start;
    logic             mode;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      pattern;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      Adr;
    logic [31:0]      MWD;
    logic             MWR;
    logic             MOE;
    logic [31:0]      MRD;

    // Engine side: consumes commands and read data, drives the memory port.
    modport master (
        input  start, mode, src_addr, dst_addr, len, pattern, MRD,
        output busy, done, words_done, Adr, MWD, MWR, MOE
    );

    // Controller/memory side.
    modport slave (
        output start, mode, src_addr, dst_addr, len, pattern, MRD,
        input  busy, done, words_done, Adr, MWD, MWR, MOE
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / pattern fill engine: owns the data memory port for a whole
// transfer, alternating READ/WRITE for copy and back-to-back WRITEs for fill.
module mem_copy_engine #(
    parameter int LEN_W = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_copy_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             mode_q;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] words_done_q;
    logic [31:0]      src_cur;
    logic [31:0]      dst_cur;
    logic [31:0]      pattern_q;
    logic [31:0]      data_reg;

    assign accept         = (state == IDLE) && bus.start;
    assign bus.words_done = words_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.Adr   = 32'h0;
        bus.MWD   = 32'h0;
        bus.MWR   = 1'b0;
        bus.MOE   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0)  state_nxt = DONE;
                    else if (bus.mode)  state_nxt = WRITE;
                    else                state_nxt = READ;
                end
            end
            READ: begin
                bus.busy  = 1'b1;
                bus.Adr   = src_cur;
                bus.MOE   = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                bus.busy = 1'b1;
                bus.Adr  = dst_cur;
                bus.MWR  = 1'b1;
                bus.MWD  = mode_q ? pattern_q : data_reg;
                if (remaining == LEN_W'(1)) state_nxt = DONE;
                else if (mode_q)            state_nxt = WRITE;
                else                        state_nxt = READ;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: reset so an aborted transfer leaves a clean engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= 1'b0;
            remaining    <= '0;
            words_done_q <= '0;
        end else if (accept) begin
            mode_q       <= bus.mode;
            remaining    <= bus.len;
            words_done_q <= '0;
        end else if (state == WRITE) begin
            remaining    <= remaining - LEN_W'(1);
            words_done_q <= words_done_q + LEN_W'(1);
        end
    end

    // Address/data registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            src_cur   <= bus.src_addr;
            dst_cur   <= bus.dst_addr;
            pattern_q <= bus.pattern;
        end else if (state == READ) begin
            data_reg <= bus.MRD;
            src_cur  <= src_cur + 32'd1;
        end else if (state == WRITE) begin
            dst_cur <= dst_cur + 32'd1;
        end
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 64-word behavioural memory
// decoding Adr[5:0]; expected values are hand-computed per scenario.
module tb_mem_copy_engine;
    localparam int LEN_W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_if #(.LEN_W(LEN_W)) bus ();

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:63];
    logic        load_en = 1'b0;
    logic [5:0]  load_adr = '0;
    logic [31:0] load_dat = '0;

    always @(posedge clk) begin
        if (load_en)      mem[load_adr] <= load_dat;
        else if (bus.MWR) mem[bus.Adr[5:0]] <= bus.MWD;
    end
    assign bus.MRD = bus.MOE ? mem[bus.Adr[5:0]] : 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        load_en  = 1'b1;
        load_adr = a[5:0];
        load_dat = d;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    int          r_done_cyc, r_done_cnt, r_moe, r_mwr, r_ovl, r_nwr;
    logic [31:0] r_adr0, r_adr1;

    // Issues one start, then scrambles all command inputs; optional stray start at glitch_cyc.
    task automatic run_xfer(input logic m, input logic [31:0] src, input logic [31:0] dst,
                            input int l, input logic [31:0] pat, input int glitch_cyc);
        int lim;
        lim = 2 * l + 4;
        r_done_cyc = 0; r_done_cnt = 0; r_moe = 0; r_mwr = 0; r_ovl = 0; r_nwr = 0;
        r_adr0 = 32'hx; r_adr1 = 32'hx;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.src_addr = src; bus.dst_addr = dst;
        bus.len = l[LEN_W-1:0]; bus.pattern = pat;
        @(posedge clk);
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0; bus.mode = ~m; bus.src_addr = ~src;
                bus.dst_addr = ~dst; bus.len = ~l[LEN_W-1:0]; bus.pattern = ~pat;
            end
            if (c == glitch_cyc) begin
                bus.start = 1'b1; bus.dst_addr = 32'd40; bus.len = 7'd1;
            end
            if (glitch_cyc != 0 && c == glitch_cyc + 1) bus.start = 1'b0;
            if (bus.done) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = c;
            end
            if (bus.MOE) r_moe++;
            if (bus.MWR) begin
                r_mwr++;
                if (r_nwr == 0) r_adr0 = bus.Adr;
                if (r_nwr == 1) r_adr1 = bus.Adr;
                r_nwr++;
            end
            if (bus.MOE && bus.MWR) r_ovl++;
        end
    endtask

    initial begin
        int nd;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.len = '0; bus.pattern = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_wdone", {25'b0, bus.words_done}, 32'd0);
        chk("rst_adr", bus.Adr, 32'd0);
        chk("rst_mwr_moe", {30'b0, bus.MWR, bus.MOE}, 32'd0);
        rst_n = 1'b1;

        // Copy, no overlap
        for (int i = 0; i < 4; i++) poke(i, 32'hA0 + i);
        run_xfer(1'b0, 32'd0, 32'd16, 4, 32'h0, 0);
        chk("copy_done_cyc", r_done_cyc, 9);
        chk("copy_done_cnt", r_done_cnt, 1);
        chk("copy_wdone", {25'b0, bus.words_done}, 4);
        chk("copy_overlap", r_ovl, 0);
        chk("copy_moe_cnt", r_moe, 4);
        chk("copy_mwr_cnt", r_mwr, 4);
        chk("copy_busy_idle", {31'b0, bus.busy}, 0);
        for (int i = 0; i < 4; i++) chk("copy_mem", mem[16 + i], 32'hA0 + i);

        // Fill
        poke(11, 32'h55);
        run_xfer(1'b1, 32'd0, 32'd8, 3, 32'hDEADBEEF, 0);
        chk("fill_done_cyc", r_done_cyc, 4);
        chk("fill_moe_cnt", r_moe, 0);
        chk("fill_wdone", {25'b0, bus.words_done}, 3);
        for (int i = 0; i < 3; i++) chk("fill_mem", mem[8 + i], 32'hDEADBEEF);
        chk("fill_mem11", mem[11], 32'h55);

        // Zero length
        run_xfer(1'b0, 32'd0, 32'd20, 0, 32'h0, 0);
        chk("zero_done_cyc", r_done_cyc, 1);
        chk("zero_done_cnt", r_done_cnt, 1);
        chk("zero_mwr_moe", r_mwr + r_moe, 0);
        chk("zero_wdone", {25'b0, bus.words_done}, 0);

        // Start while busy
        poke(40, 32'h77);
        run_xfer(1'b0, 32'd0, 32'd32, 4, 32'h0, 3);
        chk("busy_done_cyc", r_done_cyc, 9);
        chk("busy_done_cnt", r_done_cnt, 1);
        chk("busy_wdone", {25'b0, bus.words_done}, 4);
        for (int i = 0; i < 4; i++) chk("busy_mem", mem[32 + i], 32'hA0 + i);
        chk("busy_mem40", mem[40], 32'h77);

        // Reset mid-copy during the 3rd WRITE (cycle 6), before its commit edge
        for (int i = 0; i < 6; i++) poke(i, 32'hA0 + i);
        for (int i = 0; i < 6; i++) poke(48 + i, 32'h0);
        nd = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.src_addr = 32'd0; bus.dst_addr = 32'd48;
        bus.len = 7'd6;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done) nd++;
        end
        chk("rmid_in_write", {31'b0, bus.MWR}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_busy", {31'b0, bus.busy}, 0);
        chk("rmid_wdone", {25'b0, bus.words_done}, 0);
        chk("rmid_adr", bus.Adr, 0);
        chk("rmid_mwd", bus.MWD, 0);
        chk("rmid_mwr_moe", {30'b0, bus.MWR, bus.MOE}, 0);
        repeat (3) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("rmid_no_done", nd, 0);
        chk("rmid_mem48", mem[48], 32'hA0);
        chk("rmid_mem49", mem[49], 32'hA1);
        chk("rmid_mem50", mem[50], 32'h0);
        rst_n = 1'b1;
        run_xfer(1'b0, 32'd0, 32'd56, 2, 32'h0, 0);
        chk("rmid_new_done_cyc", r_done_cyc, 5);
        chk("rmid_new_wdone", {25'b0, bus.words_done}, 2);
        chk("rmid_new_mem56", mem[56], 32'hA0);
        chk("rmid_new_mem57", mem[57], 32'hA1);

        // Overlapping copy, dst = src + 1
        poke(0, 32'h11);
        poke(1, 32'h22);
        run_xfer(1'b0, 32'd0, 32'd1, 3, 32'h0, 0);
        chk("ovl_done_cyc", r_done_cyc, 7);
        for (int i = 1; i < 4; i++) chk("ovl_mem", mem[i], 32'h11);

        // Address wrap in fill mode
        run_xfer(1'b1, 32'd0, 32'hFFFF_FFFF, 2, 32'h99, 0);
        chk("wrap_adr0", r_adr0, 32'hFFFF_FFFF);
        chk("wrap_adr1", r_adr1, 32'h0000_0000);
        chk("wrap_mem63", mem[63], 32'h99);
        chk("wrap_mem0", mem[0], 32'h99);
        chk("wrap_done_cyc", r_done_cyc, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
